// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
// The master holds imem_req/imem_addr steady until imem_ack is seen high.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, single outstanding imem request and a
// 2-entry {instr, pc4} FIFO feeding decode. Taken branches flush the FIFO and
// redirect the PC; an in-flight response that belongs to the old path is dropped.
//
// Optional build macro FETCH_ALIGN_CHECK_EN: a taken branch to a target that is
// not word aligned raises the sticky fetch_misalign flag and parks the unit in
// HALT until reset. Without the macro the low target bits are forced to zero.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | first cycle after reset release, no request
// WAIT   | imem_req asserted, waiting for imem_ack
// FULL   | FIFO holds two entries, no request until decode pops
// HALT   | misaligned branch target seen, no requests until reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master imem,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  input  logic         id_ready,
  output logic         if_valid,
  output logic [31:0]  if_instr,
  output logic [31:0]  if_pc4,
  output logic [5:0]   opcode,
  output logic         fetch_misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] hold_addr_q;
  logic        drop_q, drop_d;

  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_pc4_q   [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_after;

  logic [31:0] target_eff;
  logic        target_bad;
  logic        req, ack_acc, flush, push, pop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign target_eff = branch_target;
  assign target_bad = branch_target[1:0] != 2'b00;

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_q <= 1'b0;
    else if (flush && target_bad)
      misalign_q <= 1'b1;
  end

  assign fetch_misalign = misalign_q;
`else
  logic unused_tgt_bits;

  // Low target bits are discarded in this build.
  assign unused_tgt_bits = ^branch_target[1:0];
  assign target_eff      = {branch_target[31:2], 2'b00};
  assign target_bad      = 1'b0;
  assign fetch_misalign  = 1'b0;
`endif

  assign pc_plus4 = pc_q + 32'd4;
  assign req      = (state_q == S_WAIT);
  assign ack_acc  = req && imem.imem_ack;
  // Branches are ignored once halted; the FIFO is already empty there.
  assign flush    = branch_taken && (state_q != S_HALT);
  // Data is kept only if it belongs to the current path.
  assign push     = ack_acc && !drop_q && !branch_taken;
  assign pop      = if_valid && id_ready && !flush;

  assign count_after = count_q + {1'b0, push} - {1'b0, pop};

  // While a dropped request is still in flight, keep presenting its address.
  assign imem.imem_req  = req;
  assign imem.imem_addr = drop_q ? hold_addr_q : pc_q;

  // Next-state, PC and drop-flag logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;

    case (state_q)
      S_IDLE:  state_d = S_WAIT;
      S_WAIT:  if (ack_acc) state_d = (count_after == 2'd2) ? S_FULL : S_WAIT;
      S_FULL:  if (count_after < 2'd2) state_d = S_WAIT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (ack_acc) begin
      drop_d = 1'b0;
      if (push)
        pc_d = pc_plus4;
    end

    if (flush) begin
      pc_d = target_eff;
      if (req && !imem.imem_ack)
        drop_d = 1'b1;
      if (target_bad) begin
        state_d = S_HALT;
        drop_d  = 1'b0;
      end else begin
        state_d = S_WAIT;
      end
    end
  end

  // FSM, PC and drop bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      hold_addr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      // Capture the in-flight address only on the first redirect of a request.
      if (flush && req && !imem.imem_ack && !drop_q)
        hold_addr_q <= pc_q;
    end
  end

  // FIFO pointers and occupancy; a flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_after;
    end
  end

  // FIFO storage; contents are only observed through the valid-gated outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem.imem_rdata;
      fifo_pc4_q[wr_ptr_q]   <= pc_plus4;
    end
  end

  assign if_valid = (count_q != 2'd0);
  assign if_instr = if_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign if_pc4   = if_valid ? fifo_pc4_q[rd_ptr_q] : 32'h0;
  assign opcode   = if_valid ? if_instr[31:26] : 6'h3F;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000: fetch address loaded at reset.
REQ-002 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide imem_req  output  1  instruction-memory request, held until acknowledged.
REQ-005 SHALL provide imem_addr  output  32  word address of the request.
REQ-006 SHALL provide imem_ack  input  1  completes the request in the cycle it is sampled high with imem_req.
REQ-007 SHALL provide imem_rdata  input  32  instruction word, valid when imem_ack is high.
REQ-008 SHALL provide branch_taken  input  1  single-cycle redirect pulse (Branch AND zero from execute).
REQ-009 SHALL provide branch_target  input  32  redirect address, sampled with branch_taken.
REQ-010 SHALL provide id_ready  input  1  decode stage accepts the head instruction this cycle.
REQ-011 SHALL provide if_valid  output  1  head instruction present.
REQ-012 SHALL provide if_instr  output  32  head instruction; 32'h0 when if_valid is low.
REQ-013 SHALL provide if_pc4  output  32  address of head instruction plus 4.
REQ-014 SHALL provide opcode  output  6  if_instr[31:26] when if_valid, else 6'h3F (decoded by control as no-op).
REQ-015 SHALL provide fetch_misalign  output  1  sticky misaligned-target flag (only with FETCH_ALIGN_CHECK_EN).

Function
REQ-016 SHALL hold a PC register and a 2-entry FIFO of {instr, pc4}; at most one memory request outstanding.
REQ-017 SHALL implement FSM IDLE, WAIT, FULL, HALT; IDLE->WAIT in the first cycle after reset release.
REQ-018 SHALL assert imem_req with imem_addr=PC in WAIT; addr and req stable until imem_ack.
REQ-019 SHALL on accepted ack push {imem_rdata, PC+4}, set PC<=PC+4 (modulo 2^32), and go WAIT if occupancy after push/pop <2, else FULL.
REQ-020 SHALL leave FULL for WAIT in the cycle after a pop makes occupancy <2.
REQ-021 SHALL pop the head when if_valid and id_ready; simultaneous push and pop keeps occupancy unchanged with order preserved.
REQ-022 SHALL present a fetched instruction on if_valid the cycle after its ack (1-cycle latency from ack).
REQ-023 SHALL on branch_taken flush the FIFO, ignore any same-cycle pop, and load PC<=branch_target.
REQ-024 SHALL on branch_taken while a request is outstanding and imem_ack is low set a drop flag; the next ack's data is discarded and clears the flag.
REQ-025 SHALL discard data of an ack coinciding with branch_taken.
REQ-026 SHALL issue the target request only after any outstanding request completes; redirect from FULL goes to WAIT next cycle.
REQ-027 SHALL let a later branch_taken override an earlier pending target.

Reset
REQ-028 SHALL, while rst_n is low, force PC=RESET_PC, FIFO empty, drop=0, FSM=IDLE, imem_req=0, if_valid=0, fetch_misalign=0.
REQ-029 SHALL abandon an outstanding request on reset mid-transaction; imem_req deasserts asynchronously.

Configuration
REQ-030 SHALL, with FETCH_ALIGN_CHECK_EN defined, on branch_taken with branch_target[1:0]!=0 set fetch_misalign, flush, enter HALT (no requests) until reset.
REQ-031 SHALL, without FETCH_ALIGN_CHECK_EN, force branch_target[1:0] to 2'b00 and tie fetch_misalign to 0.

Verification
REQ-032 Reset release, imem_ack always 1, id_ready=1, mem[0]=32'h8C010004 -> addresses 0,4,8 on consecutive cycles; if_instr=32'h8C010004, opcode=6'h23, if_pc4=4 one cycle after first ack.
REQ-033 id_ready=0, ack always 1 -> exactly two instructions buffered, FSM FULL, imem_req low; id_ready=1 -> imem_req high the following cycle, no loss or reorder.
REQ-034 branch_taken with target 32'h40 while request to 0x8 awaits (ack 3 cycles late) -> 0x8 data dropped, next imem_addr=0x40, first if_pc4=0x44.
REQ-035 branch_taken and imem_ack same cycle -> that data never appears; if_valid low next cycle; next request to target.
REQ-036 PC=32'hFFFF_FFFC fetch -> if_pc4=0, next imem_addr=0.
REQ-037 With FETCH_ALIGN_CHECK_EN, target 32'h42 -> fetch_misalign=1, imem_req stays 0; without it, next imem_addr=32'h40.
